// File: rtl/ycbcr_pkg.sv
// rtl/ycbcr_pkg.sv - colour matrix modes, coefficient struct and coefficient table for ycbcr2rgb_stream
package ycbcr_pkg;

    typedef enum logic [1:0] {
        YCC_601L   = 2'd0,
        YCC_601F   = 2'd1,
        YCC_709L   = 2'd2,
        YCC_BYPASS = 2'd3
    } ycc_mode_t;

    // Fields are wide enough for any MSIZE; users slice to MSIZE+2 (coefficients) / DSIZE (yoff).
    typedef struct packed {
        logic [31:0] ky;
        logic [31:0] rcr;
        logic [31:0] gcb;
        logic [31:0] gcr;
        logic [31:0] bcb;
        logic [31:0] yoff;
    } ycc_coef_t;

    // round(milli/1000 * 2^msize), round half up
    function automatic logic [31:0] fixq(input longint milli, input int msize);
        return 32'(((milli << msize) + 64'sd500) / 64'sd1000);
    endfunction

    // Bypass mode gets the BT.601 limited set, so it falls back to mode 0 when the bypass path is absent.
    function automatic ycc_coef_t ycc_coefs(input ycc_mode_t mode, input int dsize, input int msize);
        ycc_coef_t c;
        logic [31:0] yo;
        yo = 32'(16 << (dsize - 8));
        case (mode)
            YCC_601F: c = '{ky: fixq(1000, msize), rcr: fixq(1402, msize), gcb: fixq(344, msize),
                            gcr: fixq(714, msize), bcb: fixq(1772, msize), yoff: 32'd0};
            YCC_709L: c = '{ky: fixq(1164, msize), rcr: fixq(1793, msize), gcb: fixq(213, msize),
                            gcr: fixq(533, msize), bcb: fixq(2112, msize), yoff: yo};
            default:  c = '{ky: fixq(1164, msize), rcr: fixq(1596, msize), gcb: fixq(392, msize),
                            gcr: fixq(813, msize), bcb: fixq(2017, msize), yoff: yo};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ycbcr2rgb_chan.sv
// rtl/ycbcr2rgb_chan.sv - one RGB channel, products/round/clamp stages; bypass path built only with YCBCR2RGB_BYPASS_EN
module ycbcr2rgb_chan
    import ycbcr_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int MSIZE  = 12,
    parameter bit SUB_CB = 1'b0,
    parameter bit SUB_CR = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   ld,
`ifdef YCBCR2RGB_BYPASS_EN
    input  logic                   byp,
    input  logic [DSIZE-1:0]       raw,
`endif
    input  logic signed [DSIZE:0]  ym,
    input  logic signed [DSIZE:0]  cbm,
    input  logic signed [DSIZE:0]  crm,
    input  logic [MSIZE+1:0]       ky,
    input  logic [MSIZE+1:0]       kcb,
    input  logic [MSIZE+1:0]       kcr,
    output logic [DSIZE-1:0]       q
);

    localparam int AW = DSIZE + MSIZE + 4;
    localparam logic signed [AW-1:0] RND = {{(AW - MSIZE){1'b0}}, 1'b1, {(MSIZE - 1){1'b0}}};

    logic signed [AW-1:0] p_y, p_cb, p_cr;
    logic signed [AW-1:0] acc, sum3;
    logic [DSIZE-1:0]     clamped;

    // S2: the three products for this channel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_y  <= '0;
            p_cb <= '0;
            p_cr <= '0;
        end else if (en) begin
            p_y  <= AW'(ym)  * AW'($signed({1'b0, ky}));
            p_cb <= AW'(cbm) * AW'($signed({1'b0, kcb}));
            p_cr <= AW'(crm) * AW'($signed({1'b0, kcr}));
        end
    end

    // Signed sum with per-channel term signs plus the half-LSB rounding constant
    always_comb begin
        acc = p_y + (SUB_CB ? -p_cb : p_cb) + (SUB_CR ? -p_cr : p_cr) + RND;
    end

    // S3: rounded result, arithmetic shift drops the fraction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum3 <= '0;
        end else if (en) begin
            sum3 <= acc >>> MSIZE;
        end
    end

    // Clamp to the unsigned output range
    always_comb begin
        if (sum3[AW-1]) begin
            clamped = '0;
        end else if (|sum3[AW-2:DSIZE]) begin
            clamped = '1;
        end else begin
            clamped = sum3[DSIZE-1:0];
        end
    end

`ifdef YCBCR2RGB_BYPASS_EN
    logic             byp2, byp3;
    logic [DSIZE-1:0] raw2, raw3;

    // Raw component and bypass flag ride alongside S2/S3 so latency matches the matrix path
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byp2 <= 1'b0;
            byp3 <= 1'b0;
            raw2 <= '0;
            raw3 <= '0;
        end else if (en) begin
            byp2 <= byp;
            byp3 <= byp2;
            raw2 <= raw;
            raw3 <= raw2;
        end
    end

    // S4: output register, loaded only with valid pixels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (ld) begin
            q <= byp3 ? raw3 : clamped;
        end
    end
`else
    // S4: output register, loaded only with valid pixels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (ld) begin
            q <= clamped;
        end
    end
`endif

endmodule

// File: rtl/ycbcr2rgb_stream.sv
// rtl/ycbcr2rgb_stream.sv - handshaked 4-stage YCbCr to RGB converter; YCBCR2RGB_BYPASS_EN enables mode 3 pass-through
module ycbcr2rgb_stream
    import ycbcr_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int MSIZE = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_y,
    input  logic [DSIZE-1:0] in_cb,
    input  logic [DSIZE-1:0] in_cr,
    input  logic [1:0]       in_mode,
    input  logic             in_sof,
    input  logic             in_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_r,
    output logic [DSIZE-1:0] out_g,
    output logic [DSIZE-1:0] out_b,
    output logic             out_sof,
    output logic             out_eol
);

    localparam int CW = MSIZE + 2;
    localparam int VW = DSIZE + 1;
    localparam logic [VW-1:0] HALF = {2'b01, {(DSIZE - 1){1'b0}}};
    localparam ycc_coef_t CTAB [4] = '{
        ycc_coefs(YCC_601L,   DSIZE, MSIZE),
        ycc_coefs(YCC_601F,   DSIZE, MSIZE),
        ycc_coefs(YCC_709L,   DSIZE, MSIZE),
        ycc_coefs(YCC_BYPASS, DSIZE, MSIZE)
    };

    logic en;
    logic v1, v2, v3;
    logic sof1, sof2, sof3, eol1, eol2, eol3;
    logic signed [VW-1:0] ym1, cbm1, crm1;
    logic [CW-1:0] ky1, rcr1, gcb1, gcr1, bcb1;
    logic [CW-1:0] ky_n, rcr_n, gcb_n, gcr_n, bcb_n;
    logic [DSIZE-1:0] yoff_n;

    // Whole pipeline moves as one; a full output stage only drains when the sink takes it
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Coefficient set for the incoming pixel's mode
    always_comb begin
        ky_n   = CTAB[in_mode].ky[CW-1:0];
        rcr_n  = CTAB[in_mode].rcr[CW-1:0];
        gcb_n  = CTAB[in_mode].gcb[CW-1:0];
        gcr_n  = CTAB[in_mode].gcr[CW-1:0];
        bcb_n  = CTAB[in_mode].bcb[CW-1:0];
        yoff_n = CTAB[in_mode].yoff[DSIZE-1:0];
    end

    // S1: offsets removed and coefficients captured, so the mode follows its own pixel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1   <= 1'b0;
            sof1 <= 1'b0;
            eol1 <= 1'b0;
            ym1  <= '0;
            cbm1 <= '0;
            crm1 <= '0;
            ky1  <= '0;
            rcr1 <= '0;
            gcb1 <= '0;
            gcr1 <= '0;
            bcb1 <= '0;
        end else if (en) begin
            v1   <= in_valid;
            sof1 <= in_sof;
            eol1 <= in_eol;
            ym1  <= $signed({1'b0, in_y})  - $signed({1'b0, yoff_n});
            cbm1 <= $signed({1'b0, in_cb}) - $signed(HALF);
            crm1 <= $signed({1'b0, in_cr}) - $signed(HALF);
            ky1  <= ky_n;
            rcr1 <= rcr_n;
            gcb1 <= gcb_n;
            gcr1 <= gcr_n;
            bcb1 <= bcb_n;
        end
    end

    // Valid bits and frame markers for S2..S4
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            sof2      <= 1'b0;
            sof3      <= 1'b0;
            eol2      <= 1'b0;
            eol3      <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (en) begin
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            sof2      <= sof1;
            sof3      <= sof2;
            eol2      <= eol1;
            eol3      <= eol2;
            if (v3) begin
                out_sof <= sof3;
                out_eol <= eol3;
            end
        end
    end

`ifdef YCBCR2RGB_BYPASS_EN
    logic             byp1;
    logic [DSIZE-1:0] rawy1, rawcb1, rawcr1;

    // Raw components and the bypass flag for mode 3
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byp1   <= 1'b0;
            rawy1  <= '0;
            rawcb1 <= '0;
            rawcr1 <= '0;
        end else if (en) begin
            byp1   <= (in_mode == 2'd3);
            rawy1  <= in_y;
            rawcb1 <= in_cb;
            rawcr1 <= in_cr;
        end
    end
`endif

    ycbcr2rgb_chan #(.DSIZE(DSIZE), .MSIZE(MSIZE), .SUB_CB(1'b0), .SUB_CR(1'b0)) u_r (
        .clock(clock), .reset(reset), .en(en), .ld(en && v3),
`ifdef YCBCR2RGB_BYPASS_EN
        .byp(byp1), .raw(rawy1),
`endif
        .ym(ym1), .cbm(cbm1), .crm(crm1),
        .ky(ky1), .kcb('0), .kcr(rcr1), .q(out_r)
    );

    ycbcr2rgb_chan #(.DSIZE(DSIZE), .MSIZE(MSIZE), .SUB_CB(1'b1), .SUB_CR(1'b1)) u_g (
        .clock(clock), .reset(reset), .en(en), .ld(en && v3),
`ifdef YCBCR2RGB_BYPASS_EN
        .byp(byp1), .raw(rawcb1),
`endif
        .ym(ym1), .cbm(cbm1), .crm(crm1),
        .ky(ky1), .kcb(gcb1), .kcr(gcr1), .q(out_g)
    );

    ycbcr2rgb_chan #(.DSIZE(DSIZE), .MSIZE(MSIZE), .SUB_CB(1'b0), .SUB_CR(1'b0)) u_b (
        .clock(clock), .reset(reset), .en(en), .ld(en && v3),
`ifdef YCBCR2RGB_BYPASS_EN
        .byp(byp1), .raw(rawcr1),
`endif
        .ym(ym1), .cbm(cbm1), .crm(crm1),
        .ky(ky1), .kcb(bcb1), .kcr('0), .q(out_b)
    );

endmodule
